// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin two-port sequencer for the shared 16x8 program ROM bus.
// Each access drives the address with OE low for SETTLE_CYCLES, captures the byte, then acks.
module rom_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       low_rst,
  input  logic       req0,
  input  logic [3:0] addr0,
  output logic       ack0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic [3:0] addr1,
  output logic       ack1,
  output logic [7:0] rdata1,
  output logic       busy,
  output logic [3:0] rom_addr,
  output logic       low_rom_oe,
  input  logic [7:0] rom_data
);
  typedef enum logic [1:0] {IDLE, DRIVE, ACK} state_t;
  localparam logic [3:0] LOAD = 4'(SETTLE_CYCLES - 1);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic       port_q, port_d, ptr_q, ptr_d, gnt;
  assign gnt = (req0 && req1) ? ptr_q : req1;
  always_ff @(posedge clk or negedge low_rst) begin
    if (!low_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      port_q   <= 1'b0;
      ptr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      port_q   <= port_d;
      ptr_q    <= ptr_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    port_d   = port_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: if (req0 || req1) begin
        state_d = DRIVE;
        cnt_d   = LOAD;
        port_d  = gnt;
        ptr_d   = ~gnt;
        addr_d  = gnt ? addr1 : addr0;
      end
      DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d  = ACK;
          rdata0_d = port_q ? rdata0_q : rom_data;
          rdata1_d = port_q ? rom_data : rdata1_q;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // OE follows the registered state so reset releases the bus without a clock
  assign low_rom_oe = state_q != DRIVE;
  assign busy       = state_q != IDLE;
  assign ack0       = state_q == ACK && !port_q;
  assign ack1       = state_q == ACK && port_q;
  assign rom_addr   = addr_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: three arbiters (SETTLE_CYCLES 1..3) checked by directed scenarios
// and a randomized run against a timeline-level model of each access.
module tb_rom_arbiter;
  localparam int N = 3;
  logic       clk = 1'b0;
  logic       low_rst = 1'b0;
  logic       req0 [N], req1 [N], ack0 [N], ack1 [N], busy [N], low_rom_oe [N], ovr_en [N];
  logic [3:0] addr0 [N], addr1 [N], rom_addr [N];
  logic [7:0] rdata0 [N], rdata1 [N], rom_data [N], ovr_val [N];
  logic [7:0] rom [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign rom_data[g] = ovr_en[g] ? ovr_val[g] : low_rom_oe[g] ? 8'hEE : rom[rom_addr[g]];
    rom_arbiter #(.SETTLE_CYCLES(g + 1)) u_dut (
      .clk       (clk),
      .low_rst   (low_rst),
      .req0      (req0[g]),
      .addr0     (addr0[g]),
      .ack0      (ack0[g]),
      .rdata0    (rdata0[g]),
      .req1      (req1[g]),
      .addr1     (addr1[g]),
      .ack1      (ack1[g]),
      .rdata1    (rdata1[g]),
      .busy      (busy[g]),
      .rom_addr  (rom_addr[g]),
      .low_rom_oe(low_rom_oe[g]),
      .rom_data  (rom_data[g])
    );
  end

  // {busy, oe_n, ack1, ack0, rom_addr, rdata1, rdata0}
  function automatic logic [23:0] snap(input int k);
    return {busy[k], low_rom_oe[k], ack1[k], ack0[k], rom_addr[k], rdata1[k], rdata0[k]};
  endfunction

  task automatic test_reset();
    low_rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (snap(k) !== 24'h400000) begin
        errors++;
        $display("FAIL reset_values dut%0d: got %h want %h", k, snap(k), 24'h400000);
      end
    end
    low_rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (snap(k) !== 24'h400000) begin
        errors++;
        $display("FAIL idle_after_reset dut%0d: got %h want %h", k, snap(k), 24'h400000);
      end
    end
  endtask

  task automatic test_contention(input int k);
    int s = k + 1;
    int t = 0;
    int last = -1;
    int nack = 0;
    bit prev_ack = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? 8'h00 : 8'hFF;
    req0[k] = 1'b1; addr0[k] = 4'h1;
    req1[k] = 1'b1; addr1[k] = 4'hA;
    while (nack < 4 && t < 40) begin
      @(negedge clk);
      t++;
      if (prev_ack) begin
        checks++;
        if (low_rom_oe[k] !== 1'b1) begin
          errors++;
          $display("FAIL turnaround dut%0d cyc%0d: oe_n=%b want 1", k, t, low_rom_oe[k]);
        end
      end
      prev_ack = ack0[k] || ack1[k];
      if (prev_ack) begin
        checks++;
        if (ack1[k] !== 1'(nack % 2) || ack0[k] !== 1'(1 - nack % 2)) begin
          errors++;
          $display("FAIL grant_order dut%0d ack#%0d: ack1/ack0=%b%b want port %0d", k, nack, ack1[k], ack0[k], nack % 2);
        end
        checks++;
        if ((nack % 2 == 1 ? rdata1[k] : rdata0[k]) !== (nack % 2 == 1 ? 8'hFF : 8'h00)) begin
          errors++;
          $display("FAIL contention_data dut%0d ack#%0d: rd1=%h rd0=%h", k, nack, rdata1[k], rdata0[k]);
        end
        if (last >= 0) begin
          checks++;
          if (t - last != s + 2) begin
            errors++;
            $display("FAIL ack_spacing dut%0d: got %0d want %0d", k, t - last, s + 2);
          end
        end
        last = t;
        nack++;
      end
    end
    req0[k] = 1'b0;
    req1[k] = 1'b0;
    checks++;
    if (nack != 4) begin
      errors++;
      $display("FAIL contention_timeout dut%0d: acks=%0d want 4", k, nack);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle dut%0d: busy=%b want 0", k, busy[k]);
    end
  endtask

  task automatic test_single_read(input int k);
    int s = k + 1;
    logic [23:0] exp;
    req0[k] = 1'b1; addr0[k] = 4'h8;
    for (int c = 0; c < s + 2; c++) begin
      @(negedge clk);
      exp = {1'(c <= s), 1'(c >= s), 1'b0, 1'(c == s), 4'h8, 8'hFF, (c >= s) ? 8'hFF : 8'h00};
      checks++;
      if (snap(k) !== exp) begin
        errors++;
        $display("FAIL single_read dut%0d cyc%0d: got %h want %h", k, c, snap(k), exp);
      end
      if (c == s) req0[k] = 1'b0;
    end
  endtask

  task automatic test_settle(input int k);
    int s = k + 1;
    int low = 0;
    logic [7:0] v1, v2;
    v1 = 8'($urandom);
    v2 = v1 ^ 8'($urandom_range(1, 255));
    ovr_en[k] = 1'b1; ovr_val[k] = v1;
    req1[k] = 1'b1; addr1[k] = 4'hF;
    for (int c = 0; c < s + 2; c++) begin
      @(negedge clk);
      if (low_rom_oe[k] === 1'b0) low++;
      if (c == 0) begin
        checks++;
        if (rom_addr[k] !== 4'hF) begin
          errors++;
          $display("FAIL settle_addr dut%0d: got %h want f", k, rom_addr[k]);
        end
        ovr_val[k] = v2;
      end
      if (c == s) begin
        checks++;
        if (ack1[k] !== 1'b1 || rdata1[k] !== v2) begin
          errors++;
          $display("FAIL settle_capture dut%0d: ack1=%b rd1=%h want ack1=1 rd1=%h", k, ack1[k], rdata1[k], v2);
        end
        req1[k] = 1'b0;
      end
    end
    checks++;
    if (low != s) begin
      errors++;
      $display("FAIL settle_window dut%0d: oe low %0d cycles want %0d", k, low, s);
    end
    ovr_en[k] = 1'b0;
  endtask

  task automatic test_mid_access(input int k);
    int s = k + 1;
    logic [23:0] exp;
    for (int i = 0; i < 16; i++) rom[i] = {4'(i), ~4'(i)};
    req0[k] = 1'b1; addr0[k] = 4'h2;
    for (int c = 0; c < s + 2; c++) begin
      @(negedge clk);
      exp = {1'(c <= s), 1'(c >= s), 1'b0, 1'(c == s), 4'h2, 8'h00, (c >= s) ? rom[2] : 8'h00};
      checks++;
      if (snap(k) !== exp) begin
        errors++;
        $display("FAIL mid_access dut%0d cyc%0d: got %h want %h", k, c, snap(k), exp);
      end
      if (c == 0) begin
        addr0[k] = 4'h9;
        req0[k] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid(input int k);
    int s = k + 1;
    int acks = 0;
    req0[k] = 1'b1; addr0[k] = 4'h3; addr1[k] = 4'hC;
    @(negedge clk);
    checks++;
    if (low_rom_oe[k] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre dut%0d: oe_n=%b want 0", k, low_rom_oe[k]);
    end
    #2 low_rst = 1'b0;
    #1;
    checks++;
    if (low_rom_oe[k] !== 1'b1 || busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async dut%0d: oe_n=%b busy=%b want 1/0", k, low_rom_oe[k], busy[k]);
    end
    req1[k] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ack0[k] !== 1'b0 || ack1[k] !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reset_no_ack dut%0d: %0d acks want 0", k, acks);
    end
    low_rst = 1'b1;
    for (int c = 0; c <= s; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (rom_addr[k] !== 4'h3 || low_rom_oe[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_regrant dut%0d: addr=%h oe_n=%b want 3/0", k, rom_addr[k], low_rom_oe[k]);
        end
      end
      if (c == s) begin
        checks++;
        if (ack0[k] !== 1'b1 || ack1[k] !== 1'b0 || rdata0[k] !== rom[3]) begin
          errors++;
          $display("FAIL reset_regrant_ack dut%0d: ack1/ack0=%b%b rd0=%h want 01 %h", k, ack1[k], ack0[k], rdata0[k], rom[3]);
        end
      end
    end
    req0[k] = 1'b0;
    req1[k] = 1'b0;
  endtask

  task automatic test_random(input int k, input int cycles);
    int s = k + 1;
    int e0 = -1000;
    int next_free = 0;
    bit ptr = 1'b0;
    bit port_m = 1'b0;
    bit ack_p, bz, oel;
    logic [3:0] a_m = 4'h0;
    logic [7:0] rd_m [2];
    logic [23:0] exp;
    rd_m[0] = 8'h00;
    rd_m[1] = 8'h00;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    req0[k] = 1'b0;
    req1[k] = 1'b0;
    low_rst = 1'b0;
    @(negedge clk);
    low_rst = 1'b1;
    for (int t = 0; t < cycles; t++) begin
      @(posedge clk);
      if (t >= next_free && (req0[k] || req1[k])) begin
        port_m = (req0[k] && req1[k]) ? ptr : req1[k];
        ptr = !port_m;
        a_m = port_m ? addr1[k] : addr0[k];
        e0 = t;
        next_free = t + s + 2;
      end
      if (t == e0 + s) rd_m[port_m] = rom[a_m];
      @(negedge clk);
      ack_p = t == e0 + s;
      bz = t >= e0 && t <= e0 + s;
      oel = t >= e0 && t < e0 + s;
      exp = {bz, !oel, ack_p && port_m, ack_p && !port_m, a_m, rd_m[1], rd_m[0]};
      checks++;
      if (snap(k) !== exp) begin
        errors++;
        $display("FAIL random dut%0d cyc%0d: got %h want %h", k, t, snap(k), exp);
      end
      if (ack_p && !port_m) req0[k] = 1'b0;
      else if (!req0[k]) begin
        if ($urandom_range(0, 2) == 0) begin req0[k] = 1'b1; addr0[k] = 4'($urandom); end
      end else if ($urandom_range(0, 7) == 0) addr0[k] = 4'($urandom);
      else if (oel && !port_m && $urandom_range(0, 9) == 0) req0[k] = 1'b0;
      if (ack_p && port_m) req1[k] = 1'b0;
      else if (!req1[k]) begin
        if ($urandom_range(0, 2) == 0) begin req1[k] = 1'b1; addr1[k] = 4'($urandom); end
      end else if ($urandom_range(0, 7) == 0) addr1[k] = 4'($urandom);
      else if (oel && port_m && $urandom_range(0, 9) == 0) req1[k] = 1'b0;
    end
    req0[k] = 1'b0;
    req1[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0; addr0[k] = 4'h0; addr1[k] = 4'h0;
      ovr_en[k] = 1'b0; ovr_val[k] = 8'h00;
    end
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    test_reset();
    test_contention(0);
    test_single_read(0);
    test_settle(2);
    test_mid_access(1);
    test_reset_mid(2);
    for (int k = 0; k < N; k++) test_random(k, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
